// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encodings and fetch-state encoding for the instruction fetch stage.
package if_fetch_pkg;

    localparam int STALL_W = 6;
    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NOSTOP  = 1'b0;
    localparam logic DISABLE = 1'b0;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    localparam int IC_ENTRIES = 32;
    localparam int IC_IDX_W   = 5;
    localparam int IC_TAG_W   = ADDR_W - IC_IDX_W - 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4,
        S_HOLD = 3'd5
    } fetch_state_e;

    function automatic logic [1:0] byte_index(fetch_state_e s);
        case (s)
            S_B1:    return 2'd1;
            S_B2:    return 2'd2;
            S_B3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped 32-entry instruction cache: combinational lookup, single-word fill.
module if_icache
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic [INST_W-1:0] hit_inst_o,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_pc_i,
    input  logic [INST_W-1:0] fill_inst_i
);

    logic [IC_ENTRIES-1:0] valid_q;
    logic [IC_TAG_W-1:0]   tag_q  [IC_ENTRIES];
    logic [INST_W-1:0]     data_q [IC_ENTRIES];

    logic [IC_IDX_W-1:0] lk_idx;
    logic [IC_IDX_W-1:0] fl_idx;
    logic                unused_pc_lsbs;

    assign lk_idx = lookup_pc_i[IC_IDX_W+1:2];
    assign fl_idx = fill_pc_i[IC_IDX_W+1:2];
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], fill_pc_i[1:0]};

    assign hit_o      = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_pc_i[ADDR_W-1:IC_IDX_W+2]);
    assign hit_inst_o = data_q[lk_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[fl_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[fl_idx]  <= fill_pc_i[ADDR_W-1:IC_IDX_W+2];
            data_q[fl_idx] <= fill_inst_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit word from four little-endian byte reads.
// Optional instruction cache is enabled by defining IF_ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               mem_ready,
    input  logic [7:0]         mem_rdata,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               if_flag,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INST_W-1:0]  if_inst,
    output logic               stallreq
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [23:0]       buf_q, buf_d;
    logic              flag_q, flag_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    logic              ic_hit;
    logic [INST_W-1:0] ic_inst;
    logic              hit_w;
    logic              done_w;
    logic              unused_inputs;

    assign unused_inputs = ^{stall[STALL_W-1:2], stall[0], branch_target[1:0]};

`ifdef IF_ICACHE_EN
    logic fill_w;
    assign fill_w = done_w && !hit_w;

    if_icache u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc_i (pc_q),
        .hit_o       (ic_hit),
        .hit_inst_o  (ic_inst),
        .fill_i      (fill_w),
        .fill_pc_i   (pc_q),
        .fill_inst_i ({mem_rdata, buf_q})
    );
`else
    assign ic_hit  = DISABLE;
    assign ic_inst = ZERO_WORD;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        flag_d   = flag_q;
        ipc_d    = ipc_q;
        inst_d   = inst_q;
        hit_w    = (state_q == S_B0) && ic_hit;
        done_w   = 1'b0;
        mem_req  = 1'b0;
        stallreq = 1'b0;
        mem_addr = pc_q + {30'd0, byte_index(state_q)};

        case (state_q)
            S_IDLE: state_d = S_B0;
            S_B0, S_B1, S_B2, S_B3: begin
                mem_req  = !hit_w;
                stallreq = !hit_w;
                flag_d   = 1'b0;
                // A redirect wins over everything, including a word completing this cycle.
                if (branch_flag) begin
                    pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
                    state_d = S_B0;
                end else if (hit_w) begin
                    done_w = 1'b1;
                end else if (mem_ready) begin
                    case (state_q)
                        S_B0: begin buf_d[7:0]   = mem_rdata; state_d = S_B1; end
                        S_B1: begin buf_d[15:8]  = mem_rdata; state_d = S_B2; end
                        S_B2: begin buf_d[23:16] = mem_rdata; state_d = S_B3; end
                        default: done_w = 1'b1;
                    endcase
                end
            end
            S_HOLD: begin
                if (branch_flag) begin
                    pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
                    flag_d  = 1'b0;
                    state_d = S_B0;
                end else if (stall[1] == NOSTOP) begin
                    flag_d  = 1'b0;
                    state_d = S_B0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_w) begin
            flag_d  = 1'b1;
            ipc_d   = pc_q;
            inst_d  = hit_w ? ic_inst : {mem_rdata, buf_q};
            pc_d    = pc_q + 32'd4;
            state_d = (stall[1] == STOP) ? S_HOLD : S_B0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            buf_q   <= '0;
            flag_q  <= 1'b0;
            ipc_q   <= '0;
            inst_q  <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            flag_q  <= flag_d;
            ipc_q   <= ipc_d;
            inst_q  <= inst_d;
        end
    end

    assign if_flag = flag_q;
    assign if_pc   = ipc_q;
    assign if_inst = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector tables, async-reset sequence, random run against a word-level model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_flag;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .if_flag       (if_flag),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stallreq      (stallreq)
    );

    function automatic logic [7:0] mem_byte(logic [31:0] a);
        logic [31:0] w0;
        w0 = 32'h00000513;
        if (a < 32'd4) return w0[8*a[1:0] +: 8];
        return a[7:0] ^ a[15:8] ^ 8'hA5 ^ {a[4:0], a[31:29]};
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    assign mem_rdata = mem_byte(mem_addr);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic stop, logic br, logic [31:0] tgt, logic rdy);
        rst           = r;
        stall         = {4'b0000, stop, 1'b0};
        branch_flag   = br;
        branch_target = tgt;
        mem_ready     = rdy;
    endtask

    typedef struct {
        logic        r;
        logic        stop;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_flag;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic row(logic r, logic stop, logic br, logic [31:0] tgt, logic rdy,
                       logic ef, logic [31:0] epc, logic [31:0] einst, logic ereq, logic [31:0] eaddr);
        vec_t v;
        v.r = r; v.stop = stop; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.e_flag = ef; v.e_pc = epc; v.e_inst = einst; v.e_req = ereq; v.e_addr = eaddr;
        tbl.push_back(v);
    endtask

    task automatic run_table(string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].stop, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].if_flag", tag, i), {31'd0, if_flag}, {31'd0, tbl[i].e_flag});
            chk($sformatf("%s[%0d].mem_req", tag, i), {31'd0, mem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("%s[%0d].stallreq", tag, i), {31'd0, stallreq}, {31'd0, tbl[i].e_req});
            if (tbl[i].e_req || !tbl[i].r)
                chk($sformatf("%s[%0d].mem_addr", tag, i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_flag || !tbl[i].r) begin
                chk($sformatf("%s[%0d].if_pc", tag, i), if_pc, tbl[i].e_pc);
                chk($sformatf("%s[%0d].if_inst", tag, i), if_inst, tbl[i].e_inst);
            end
        end
        tbl.delete();
    endtask

    // Word-level model state for the random run.
    bit          m_started;
    int          m_bytes;
    bit          m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #2;

        row(0,0,0,32'h0,0,   0,32'h0,32'h0,0,32'h0);
        row(1,0,0,32'h0,0,   0,32'h0,32'h0,1,32'h0);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h1);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h2);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h3);
        row(1,0,0,32'h0,1,   1,32'h0,32'h00000513,1,32'h4);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h5);
        row(1,0,0,32'h0,0,   0,32'h0,32'h0,1,32'h5);
        row(1,0,0,32'h0,0,   0,32'h0,32'h0,1,32'h5);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h6);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h7);
        row(1,0,0,32'h0,1,   1,32'h4,word_at(32'h4),1,32'h8);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h9);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'hA);
        row(1,0,1,32'h102,1, 0,32'h0,32'h0,1,32'h100);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h101);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h102);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h103);
        row(1,1,0,32'h0,1,   1,32'h100,word_at(32'h100),0,32'h0);
        row(1,1,0,32'h0,1,   1,32'h100,word_at(32'h100),0,32'h0);
        row(1,1,0,32'h0,1,   1,32'h100,word_at(32'h100),0,32'h0);
        row(1,0,0,32'h0,0,   0,32'h0,32'h0,1,32'h104);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h105);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h106);
        run_table("basic");

        // Asynchronous reset in the middle of B2: outputs must clear before any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.if_flag", {31'd0, if_flag}, 32'd0);
        chk("async_rst.if_pc", if_pc, 32'd0);
        chk("async_rst.if_inst", if_inst, 32'd0);
        chk("async_rst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst.mem_addr", mem_addr, 32'd0);
        chk("async_rst.stallreq", {31'd0, stallreq}, 32'd0);
        @(negedge clk);

        row(0,0,0,32'h0,1,        0,32'h0,32'h0,0,32'h0);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h0);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h1);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h2);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h3);
        row(1,0,1,32'h43,1,       0,32'h0,32'h0,1,32'h40);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h41);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h42);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'h43);
        row(1,1,0,32'h0,1,        1,32'h40,word_at(32'h40),0,32'h0);
        row(1,1,1,32'hFFFFFFFE,1, 0,32'h0,32'h0,1,32'hFFFFFFFC);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'hFFFFFFFD);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'hFFFFFFFE);
        row(1,0,0,32'h0,1,        0,32'h0,32'h0,1,32'hFFFFFFFF);
        row(1,0,0,32'h0,1,        1,32'hFFFFFFFC,word_at(32'hFFFFFFFC),1,32'h0);
        run_table("edge");

`ifdef IF_ICACHE_EN
        row(0,0,0,32'h0,0,   0,32'h0,32'h0,0,32'h0);
        row(1,0,0,32'h0,0,   0,32'h0,32'h0,1,32'h0);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h1);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h2);
        row(1,0,0,32'h0,1,   0,32'h0,32'h0,1,32'h3);
        row(1,0,0,32'h0,1,   1,32'h0,32'h00000513,1,32'h4);
        row(1,0,1,32'h0,0,   0,32'h0,32'h0,0,32'h0);
        row(1,0,0,32'h0,0,   1,32'h0,32'h00000513,1,32'h4);
        run_table("icache");
`else
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_started = 1'b0;
        m_bytes   = 0;
        m_hold    = 1'b0;
        m_pc      = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            logic stop, br, rdy, e_flag;
            logic [31:0] tgt;
            rdy  = ($urandom_range(0, 3) != 0);
            stop = ($urandom_range(0, 4) == 0);
            br   = ($urandom_range(0, 39) == 0);
            tgt  = $urandom;
            drive(1'b1, stop, br, tgt, rdy);
            @(posedge clk);
            #1;
            e_flag = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (br) begin
                m_pc    = {tgt[31:2], 2'b00};
                m_bytes = 0;
                m_hold  = 1'b0;
            end else if (m_hold) begin
                if (stop) e_flag = 1'b1;
                else m_hold = 1'b0;
            end else if (rdy) begin
                m_bytes++;
                if (m_bytes == 4) begin
                    e_flag      = 1'b1;
                    m_last_pc   = m_pc;
                    m_last_inst = word_at(m_pc);
                    m_pc        = m_pc + 32'd4;
                    m_bytes     = 0;
                    m_hold      = stop;
                end
            end
            chk("rand.if_flag", {31'd0, if_flag}, {31'd0, e_flag});
            chk("rand.stallreq", {31'd0, stallreq}, {31'd0, !m_hold});
            chk("rand.mem_req", {31'd0, mem_req}, {31'd0, !m_hold});
            if (!m_hold)
                chk("rand.mem_addr", mem_addr, m_pc + m_bytes);
            if (e_flag) begin
                chk("rand.if_pc", if_pc, m_last_pc);
                chk("rand.if_inst", if_inst, m_last_inst);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
